mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 77 +++++++
 tb/tb_mem_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word RAM responder for the LC-3 memory interface; optional IO at 0xFFFF (MEM_IO_HEX_EN).
// Ports: Clk/Reset (sync, active-high); MEM_EN/WE/MAR/MDR request; SW switch input; MDR_In read data; R ready pulse; busy; HEX_REG display.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_EN,
  input  logic        WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] SW,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic        busy,
  output logic [15:0] HEX_REG
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q, data_q, rdata_q;
  logic        we_q, r_q;
  logic [15:0] mem [2**ADDR_W];
  logic        done, in_ram, is_io;
  logic [15:0] rd_d;
  assign done   = state_q == ACCESS && cnt_q == 4'd0;
  assign in_ram = (addr_q >> ADDR_W) == 16'd0;
`ifdef MEM_IO_HEX_EN
  assign is_io  = addr_q == 16'hFFFF;
`else
  assign is_io  = 1'b0;
`endif
  assign rd_d   = in_ram ? mem[addr_q[ADDR_W-1:0]] : is_io ? SW : 16'h0000;
  assign busy   = state_q != IDLE;
  assign R      = r_q;
  assign MDR_In = rdata_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      we_q    <= 1'b0;
      rdata_q <= 16'h0000;
      r_q     <= 1'b0;
    end else begin
      r_q <= done;
      case (state_q)
        IDLE: if (MEM_EN) begin
          state_q <= ACCESS;
          cnt_q   <= 4'(WAIT_CYCLES);
          addr_q  <= MAR;
          data_q  <= MDR;
          we_q    <= WE;
        end
        ACCESS: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else begin
          state_q <= RESP;
          if (!we_q) rdata_q <= rd_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge Clk)
    if (!Reset && done && we_q && in_ram) mem[addr_q[ADDR_W-1:0]] <= data_q;
`ifdef MEM_IO_HEX_EN
  logic [15:0] hex_q;
  always_ff @(posedge Clk)
    if (Reset) hex_q <= 16'h0000;
    else if (done && we_q && is_io) hex_q <= data_q;
  assign HEX_REG = hex_q;
`else
  assign HEX_REG = 16'h0000;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed table-driven bench for mem_responder plus multi-cycle corner sequences.
module tb_mem_responder;
  localparam int W = 2;
`ifdef MEM_IO_HEX_EN
  localparam logic [15:0] IO_RD = 16'h5A5A, IO_HEX = 16'h00AB;
`else
  localparam logic [15:0] IO_RD = 16'h0000, IO_HEX = 16'h0000;
`endif
  logic Clk = 0, Reset = 1, MEM_EN = 0, WE = 0;
  logic [15:0] MAR = 0, MDR = 0, SW = 0;
  logic [15:0] MDR_In, HEX_REG;
  logic R, busy;
  logic c_en = 0, c_we = 0;
  logic [15:0] c_mar = 0, c_mdr = 0, c_rd, c_hex;
  logic c_R, c_busy;
  int n_chk = 0, n_fail = 0;
  always #5 Clk = ~Clk;
  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset), .MEM_EN(MEM_EN), .WE(WE), .MAR(MAR), .MDR(MDR), .SW(SW),
    .MDR_In(MDR_In), .R(R), .busy(busy), .HEX_REG(HEX_REG));
  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .MEM_EN(c_en), .WE(c_we), .MAR(c_mar), .MDR(c_mdr), .SW(16'h0000),
    .MDR_In(c_rd), .R(c_R), .busy(c_busy), .HEX_REG(c_hex));
  typedef struct {
    logic        we;
    logic [15:0] a, d, sw, rd, hex;
  } vec_t;
  vec_t v[11];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d, output int lat, output logic [15:0] rd);
    @(negedge Clk);
    MEM_EN = 1; WE = we; MAR = a; MDR = d;
    @(posedge Clk);
    @(negedge Clk);
    MEM_EN = 0;
    lat = 0;
    while (!R && lat < 20) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end
    rd = MDR_In;
    chk("busy_at_R", 16'(busy), 16'd1);
    @(posedge Clk);
    @(negedge Clk);
    chk("R_falls", 16'(R), 16'd0);
    chk("idle_after", 16'(busy), 16'd0);
  endtask
  initial begin
    int lat, cyc, np, last, idle;
    logic [15:0] rd;
    logic seen;
    v[0]  = '{1'b1, 16'h0005, 16'h1234, 16'h0000, 16'h0000, 16'h0000};
    v[1]  = '{1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h1234, 16'h0000};
    v[2]  = '{1'b0, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    v[3]  = '{1'b1, 16'h0000, 16'hCAFE, 16'h0000, 16'h0000, 16'h0000};
    v[4]  = '{1'b1, 16'h0400, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
    v[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 16'h0000};
    v[6]  = '{1'b1, 16'hFFFF, 16'h00AB, 16'h0000, 16'hCAFE, IO_HEX};
    v[7]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h5A5A, IO_RD, IO_HEX};
    v[8]  = '{1'b1, 16'h0003, 16'h0A0A, 16'h0000, IO_RD, IO_HEX};
    v[9]  = '{1'b1, 16'h0004, 16'h4444, 16'h0000, IO_RD, IO_HEX};
    v[10] = '{1'b0, 16'h03FF, 16'h0000, 16'h0000, 16'h0000, IO_HEX};
    v[10].we = 1'b1; v[10].d = 16'h7777; v[10].rd = IO_RD;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
    chk("rst_MDR_In", MDR_In, 16'h0000);
    chk("rst_R", 16'(R), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_HEX", HEX_REG, 16'h0000);
    for (int i = 0; i < 11; i++) begin
      SW = v[i].sw;
      access(v[i].we, v[i].a, v[i].d, lat, rd);
      chk($sformatf("v%0d_lat", i), 16'(lat), 16'(W + 1));
      chk($sformatf("v%0d_rd", i), rd, v[i].rd);
      chk($sformatf("v%0d_hex", i), HEX_REG, v[i].hex);
    end
    // read 0x0003 while request inputs churn during ACCESS
    @(negedge Clk);
    MEM_EN = 1; WE = 0; MAR = 16'h0003;
    @(posedge Clk);
    lat = 0;
    @(negedge Clk);
    while (!R && lat < 20) begin
      MEM_EN = lat[0]; WE = 1; MAR = 16'h0004; MDR = 16'hDEAD;
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end
    MEM_EN = 0; WE = 0;
    chk("ign_lat", 16'(lat), 16'(W + 1));
    chk("ign_rd", MDR_In, 16'h0A0A);
    access(1'b0, 16'h0004, 16'h0000, lat, rd);
    chk("ign_0004", rd, 16'h4444);
    access(1'b0, 16'h03FF, 16'h0000, lat, rd);
    chk("ram_top", rd, 16'h7777);
    // reset during ACCESS aborts a pending write
    access(1'b1, 16'h0007, 16'h1111, lat, rd);
    @(negedge Clk);
    MEM_EN = 1; WE = 1; MAR = 16'h0007; MDR = 16'h2222;
    @(posedge Clk);
    @(negedge Clk);
    MEM_EN = 0; Reset = 1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
    chk("abort_busy", 16'(busy), 16'd0);
    seen = 0;
    repeat (6) begin
      if (R) seen = 1;
      @(negedge Clk);
    end
    chk("abort_noR", 16'(seen), 16'd0);
    access(1'b0, 16'h0007, 16'h0000, lat, rd);
    chk("abort_rd", rd, 16'h1111);
    chk("abort_hold", MDR_In, 16'h1111);
    // reset on the completion edge wins
    access(1'b1, 16'h0008, 16'h3333, lat, rd);
    @(negedge Clk);
    MEM_EN = 1; WE = 1; MAR = 16'h0008; MDR = 16'h9999;
    @(posedge Clk);
    @(negedge Clk);
    MEM_EN = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
    chk("late_rst_R", 16'(R), 16'd0);
    chk("late_rst_busy", 16'(busy), 16'd0);
    chk("late_rst_MDR", MDR_In, 16'h0000);
    access(1'b0, 16'h0008, 16'h0000, lat, rd);
    chk("late_rst_rd", rd, 16'h3333);
    // reset together with MEM_EN in IDLE is not accepted
    @(negedge Clk);
    Reset = 1; MEM_EN = 1; WE = 0; MAR = 16'h0005;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 0; MEM_EN = 0;
    chk("rst_en_busy", 16'(busy), 16'd0);
    // zero-wait instance with MEM_EN held high
    @(negedge Clk);
    c_en = 1; c_we = 1; c_mar = 16'h0001; c_mdr = 16'h0101;
    cyc = 0; np = 0; last = 0; idle = 0;
    while (np < 4 && cyc < 60) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      if (np >= 1 && !c_busy) idle++;
      if (c_R) begin
        if (np == 0) chk("z_first_lat", 16'(cyc), 16'd2);
        else chk($sformatf("z_period%0d", np), 16'(cyc - last), 16'd3);
        if (np == 2) chk("z_rd1", c_rd, 16'h0101);
        if (np == 3) chk("z_rd2", c_rd, 16'h0202);
        last = cyc;
        np++;
        c_we = np < 2;
        c_mar = np[0] ? 16'h0002 : 16'h0001;
        c_mdr = 16'h0202;
        if (np == 4) c_en = 0;
      end
    end
    chk("z_pulses", 16'(np), 16'd4);
    chk("z_idle_gaps", 16'(idle), 16'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
